alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Execute-stage front end that sits directly upstream of the ALU and owns its control inputs.
- Issues single-cycle ALU operations, and sequences the 4-cycle ACCUMBYTES reduction by driving the cycle count and feeding each partial result back into the ALU A operand.
- Registers the ALU result and the Z/C/V/N flags for the writeback stage.
- Stalls the decode stage while a multi-cycle operation or a downstream hold is in progress.

Parameters:
- DATA_W, 40, operand/result width; must match the ALU datapath.
- OP_W, 5, opcode width; opcode values come from opcodes.inc.
- CNT_W, 3, ALU cycle-count width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- controlInIssueValid  input  1  decode presents an operation this cycle.
- controlInIssueOp  input  OP_W  opcode of the presented operation.
- controlInIssueShiftDir  input  2  MOV shift direction.
- dataInOpA  input  DATA_W  operand A.
- dataInOpB  input  DATA_W  operand B.
- controlInHold  input  1  downstream hold; freezes the block.
- controlOutStall  output  1  decode must not advance.
- dataOutALUa  output  DATA_W  ALU operand A.
- dataOutALUb  output  DATA_W  ALU operand B.
- controlOutALUop  output  OP_W  ALU opcode.
- controlOutALUshiftDir  output  2  ALU shift direction.
- controlOutALUCycleCnt  output  CNT_W  ALU cycle count.
- dataInALUresult  input  DATA_W  ALU result.
- controlInAluZ / controlInAluC / controlInAluV / controlInAluN  input  1 each  ALU flags.
- dataOutResult  output  DATA_W  registered result.
- controlOutResultValid  output  1  result/flags valid; one-cycle pulse per operation.
- controlOutZ / controlOutC / controlOutV / controlOutN  output  1 each  registered flags.

Behaviour:
- Reset (rst high, asynchronous): state=IDLE; cnt=0; dataOutResult=0; all registered flags=0; controlOutResultValid=0; internal operand/op registers=0.
- States are IDLE and ACCUM.
- Accept condition: issue accepted when state==IDLE && controlInIssueValid && !controlInHold.
- controlOutStall = controlInHold || (state==ACCUM).

IDLE:
- ALU ports are driven combinationally from the issue inputs: a=dataInOpA, b=dataInOpB, op=controlInIssueOp, shiftDir=controlInIssueShiftDir, cycleCnt=0.
- On accept of a non-ACCUMBYTES op: the next edge registers ALU result and flags, and pulses controlOutResultValid. Latency is 1.
- On accept of ACCUMBYTES: the next edge registers the ALU result into the internal A register, sets cnt=1, and moves to ACCUM. No valid pulse.

ACCUM:
- ALU driven as a=internal A, b=0, op=ACCUMBYTES, cycleCnt=cnt.
- For cnt 1 and 2: each edge registers the result into internal A and does cnt+1.
- For cnt 3: the edge registers result and flags to the outputs, pulses valid, clears cnt, and returns to IDLE.
- Total latency from accept to valid is 4 cycles.
- Result equals the unsigned sum of bytes [23:0] of A plus bytes [23:0] of B, zero-extended to DATA_W.
- The C/V/N/Z reported are the ALU flags of the cnt=3 cycle.

General rules:
- controlInHold high: no state, counter, internal register or output register changes. controlOutResultValid holds its value.
- Valid low in IDLE: outputs hold, valid=0.
- Valid is a single-cycle pulse except while extended by hold.
- Issue presented during ACCUM is ignored; decode is stalled.
- rst asserted mid-ACCUM aborts immediately to reset values. No result is produced.
- Default/unknown opcodes are passed through unchanged; the result is whatever the ALU produces.

Optional Feature:
- Macro: ALU_SEQ_ILLEGAL_OP_TRAP_EN.
- Defined:
  - Adds output controlOutIllegalOp (1 bit).
  - An accepted opcode not listed in opcodes.inc is still passed to the ALU.
  - Its result is still registered, and the valid pulse is still produced.
  - controlOutIllegalOp pulses high together with that valid pulse.
  - controlOutIllegalOp resets to 0.
- Undefined: the port is absent; unknown opcodes are passed through silently.

Decomposition:
- Shared package: the opcodes.inc constants (including ACCUMBYTES), the state encoding IDLE/ACCUM, and ACCUM_LAST_CNT=3.
- One natural sub-module: alu_seq_outreg, the hold-gated result/flag/valid register, reused by the other execute units.

Test Plan:
- ADD accept: A=5, B=7 -> next cycle dataOutResult=12, valid=1 for one cycle, Z=0, stall=0 throughout.
- ACCUMBYTES: A[23:0]=0x030201, B[23:0]=0x010101 -> stall high for cycles 2-4, cycleCnt sequence 0,1,2,3, valid at cycle 4 with result=9.
- ACCUMBYTES with all bytes 0xFF -> result=0x5FA (1530); an issue presented during ACCUM is not accepted.
- Hold asserted at cnt=2 for 3 cycles -> cnt stays 2, ALU inputs unchanged; after release, result valid 2 cycles later and correct.
- rst pulsed at cnt=1 -> all outputs 0 at once, state IDLE; the next ADD completes with latency 1.
- Macro defined: unlisted opcode 5'h1F -> valid and controlOutIllegalOp both pulse one cycle after accept.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared execute-stage constants: ALU opcodes, sequencer state encoding, flag bundle.
// Also used by the other execute units that reuse alu_seq_outreg.
package alu_op_sequencer_pkg;

  localparam int OP_WIDTH = 5;

  localparam logic [OP_WIDTH-1:0] OP_NOP        = 5'h00;
  localparam logic [OP_WIDTH-1:0] OP_ADD        = 5'h01;
  localparam logic [OP_WIDTH-1:0] OP_SUB        = 5'h02;
  localparam logic [OP_WIDTH-1:0] OP_AND        = 5'h03;
  localparam logic [OP_WIDTH-1:0] OP_OR         = 5'h04;
  localparam logic [OP_WIDTH-1:0] OP_XOR        = 5'h05;
  localparam logic [OP_WIDTH-1:0] OP_MOV        = 5'h06;
  localparam logic [OP_WIDTH-1:0] OP_ACCUMBYTES = 5'h07;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // ACCUMBYTES runs at cycle counts 0..3; count 3 produces the final sum.
  localparam int ACCUM_LAST_CNT = 3;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } alu_flags_t;

  function automatic logic is_listed_op(input logic [OP_WIDTH-1:0] op);
    return op <= OP_ACCUMBYTES;
  endfunction

endpackage

// File: rtl/alu_seq_outreg.sv
// Hold-gated result/flag register with a one-cycle valid pulse; latency 1.
// While hold_i is high nothing changes, so a pending valid stays asserted.
module alu_seq_outreg
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] result_i,
  input  alu_flags_t        flags_i,
  output logic [DATA_W-1:0] result_o,
  output alu_flags_t        flags_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] result_q;
  alu_flags_t        flags_q;
  logic              valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else if (!hold_i) begin
      valid_q <= load_i;
      if (load_i) begin
        result_q <= result_i;
        flags_q  <= flags_i;
      end
    end
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU front end: single-cycle ops (latency 1) and the 4-cycle ACCUMBYTES reduction; stalls decode
// during ACCUM or downstream hold. ALU_SEQ_ILLEGAL_OP_TRAP_EN adds controlOutIllegalOp.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 40,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              controlInIssueValid,
  input  logic [OP_W-1:0]   controlInIssueOp,
  input  logic [1:0]        controlInIssueShiftDir,
  input  logic [DATA_W-1:0] dataInOpA,
  input  logic [DATA_W-1:0] dataInOpB,
  input  logic              controlInHold,
  output logic              controlOutStall,
  output logic [DATA_W-1:0] dataOutALUa,
  output logic [DATA_W-1:0] dataOutALUb,
  output logic [OP_W-1:0]   controlOutALUop,
  output logic [1:0]        controlOutALUshiftDir,
  output logic [CNT_W-1:0]  controlOutALUCycleCnt,
  input  logic [DATA_W-1:0] dataInALUresult,
  input  logic              controlInAluZ,
  input  logic              controlInAluC,
  input  logic              controlInAluV,
  input  logic              controlInAluN,
  output logic [DATA_W-1:0] dataOutResult,
  output logic              controlOutResultValid,
  output logic              controlOutZ,
  output logic              controlOutC,
  output logic              controlOutV,
  output logic              controlOutN
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
  ,
  output logic              controlOutIllegalOp
`endif
);

  localparam logic [OP_W-1:0]  ACCUM_OP = OP_W'(OP_ACCUMBYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCUM_LAST_CNT);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;

  logic       accept;
  logic       issue_is_accum;
  logic       accum_last;
  logic       load_result;
  alu_flags_t alu_flags;
  alu_flags_t out_flags;

  assign accept         = (state_q == ST_IDLE) && controlInIssueValid && !controlInHold;
  assign issue_is_accum = (controlInIssueOp == ACCUM_OP);
  assign accum_last     = (state_q == ST_ACCUM) && (cnt_q == LAST_CNT);
  assign load_result    = (accept && !issue_is_accum) || accum_last;

  assign controlOutStall = controlInHold || (state_q == ST_ACCUM);

  always_comb begin
    dataOutALUa           = dataInOpA;
    dataOutALUb           = dataInOpB;
    controlOutALUop       = controlInIssueOp;
    controlOutALUshiftDir = controlInIssueShiftDir;
    controlOutALUCycleCnt = '0;
    if (state_q == ST_ACCUM) begin
      // Partial sum loops back through operand A; B is consumed in the first pass.
      dataOutALUa           = a_q;
      dataOutALUb           = '0;
      controlOutALUop       = ACCUM_OP;
      controlOutALUshiftDir = 2'b00;
      controlOutALUCycleCnt = cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    if (state_q == ST_IDLE) begin
      if (accept && issue_is_accum) begin
        state_d = ST_ACCUM;
        cnt_d   = CNT_W'(1);
        a_d     = dataInALUresult;
      end
    end else if (cnt_q == LAST_CNT) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      a_d   = dataInALUresult;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
    end else if (!controlInHold) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
    end
  end

  assign alu_flags = '{z: controlInAluZ, c: controlInAluC, v: controlInAluV, n: controlInAluN};

  alu_seq_outreg #(
    .DATA_W(DATA_W)
  ) u_outreg (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (controlInHold),
    .load_i  (load_result),
    .result_i(dataInALUresult),
    .flags_i (alu_flags),
    .result_o(dataOutResult),
    .flags_o (out_flags),
    .valid_o (controlOutResultValid)
  );

  assign controlOutZ = out_flags.z;
  assign controlOutC = out_flags.c;
  assign controlOutV = out_flags.v;
  assign controlOutN = out_flags.n;

`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  // Only single-cycle issues can carry an unlisted opcode; ACCUMBYTES is listed.
  assign illegal_d = accept && !issue_is_accum && !is_listed_op(controlInIssueOp[OP_WIDTH-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (!controlInHold) begin
      illegal_q <= illegal_d;
    end
  end

  assign controlOutIllegalOp = illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU closing the loop.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_vld;
  logic [4:0]  iss_op;
  logic [1:0]  iss_dir;
  logic [39:0] op_a, op_b;
  logic        hold;
  logic        stall;
  logic [39:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [1:0]  alu_dir;
  logic [2:0]  alu_cnt;
  logic [39:0] alu_res;
  logic        fz, fc, fv, fn;
  logic [39:0] res;
  logic        res_vld;
  logic        oz, oc, ov, on;
  logic        ill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .controlInIssueValid   (iss_vld),
    .controlInIssueOp      (iss_op),
    .controlInIssueShiftDir(iss_dir),
    .dataInOpA             (op_a),
    .dataInOpB             (op_b),
    .controlInHold         (hold),
    .controlOutStall       (stall),
    .dataOutALUa           (alu_a),
    .dataOutALUb           (alu_b),
    .controlOutALUop       (alu_op),
    .controlOutALUshiftDir (alu_dir),
    .controlOutALUCycleCnt (alu_cnt),
    .dataInALUresult       (alu_res),
    .controlInAluZ         (fz),
    .controlInAluC         (fc),
    .controlInAluV         (fv),
    .controlInAluN         (fn),
    .dataOutResult         (res),
    .controlOutResultValid (res_vld),
    .controlOutZ           (oz),
    .controlOutC           (oc),
    .controlOutV           (ov),
    .controlOutN           (on)
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
    ,
    .controlOutIllegalOp   (ill)
`endif
  );

`ifndef ALU_SEQ_ILLEGAL_OP_TRAP_EN
  assign ill = 1'b0;
`endif

  // ALU model. ACCUMBYTES packs a 12-bit running sum at [39:28] and two
  // pending 9-bit byte-pair sums at [17:9] and [8:0], folding one per cycle.
  logic [11:0] acc;
  logic [8:0]  p0, p1, p2;
  always_comb begin
    alu_res = '0;
    fc = 1'b0;
    fv = 1'b0;
    acc = '0;
    p0 = 9'(alu_a[7:0]) + 9'(alu_b[7:0]);
    p1 = 9'(alu_a[15:8]) + 9'(alu_b[15:8]);
    p2 = 9'(alu_a[23:16]) + 9'(alu_b[23:16]);
    case (alu_op)
      OP_ADD: begin
        {fc, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
        fv = (alu_a[39] == alu_b[39]) && (alu_res[39] != alu_a[39]);
      end
      OP_SUB: begin
        {fc, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
        fv = (alu_a[39] != alu_b[39]) && (alu_res[39] != alu_a[39]);
      end
      OP_AND: alu_res = alu_a & alu_b;
      OP_OR:  alu_res = alu_a | alu_b;
      OP_XOR: alu_res = alu_a ^ alu_b;
      OP_MOV: begin
        case (alu_dir)
          2'd1:    alu_res = alu_b << 1;
          2'd2:    alu_res = alu_b >> 1;
          default: alu_res = alu_b;
        endcase
      end
      OP_ACCUMBYTES: begin
        case (alu_cnt)
          3'd0: alu_res = (40'(p0) << 28) | (40'(p1) << 9) | 40'(p2);
          3'd1: begin
            acc = alu_a[39:28] + 12'(alu_a[17:9]);
            alu_res = (40'(acc) << 28) | 40'(alu_a[8:0]);
          end
          3'd2: begin
            acc = alu_a[39:28] + 12'(alu_a[8:0]);
            alu_res = 40'(acc) << 28;
          end
          default: alu_res = 40'(alu_a[39:28]);
        endcase
      end
      default: alu_res = alu_a;
    endcase
    fz = (alu_res == '0);
    fn = alu_res[39];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [1:0] dir,
                       input logic [39:0] a, input logic [39:0] b);
    iss_vld = 1'b1;
    iss_op  = op;
    iss_dir = dir;
    op_a    = a;
    op_b    = b;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  dir;
    logic [39:0] a;
    logic [39:0] b;
    logic [39:0] res;
    logic [3:0]  flags;  // {Z,C,V,N}
    logic        illegal;
  } vec_t;

  vec_t vecs[9];
  logic [39:0] a_snap;

  initial begin
    vecs[0] = '{OP_ADD, 2'd0, 40'd5, 40'd7, 40'd12, 4'b0000, 1'b0};
    vecs[1] = '{OP_ADD, 2'd0, 40'd0, 40'd0, 40'd0, 4'b1000, 1'b0};
    vecs[2] = '{OP_ADD, 2'd0, 40'hFF_FFFF_FFFF, 40'd1, 40'd0, 4'b1100, 1'b0};
    vecs[3] = '{OP_SUB, 2'd0, 40'd3, 40'd5, 40'hFF_FFFF_FFFE, 4'b0101, 1'b0};
    vecs[4] = '{OP_ADD, 2'd0, 40'h7F_FFFF_FFFF, 40'd1, 40'h80_0000_0000, 4'b0011, 1'b0};
    vecs[5] = '{OP_AND, 2'd0, 40'hF0F0, 40'hFF00, 40'hF000, 4'b0000, 1'b0};
    vecs[6] = '{OP_XOR, 2'd0, 40'hAA, 40'hAA, 40'd0, 4'b1000, 1'b0};
    vecs[7] = '{OP_MOV, 2'd1, 40'd0, 40'd3, 40'd6, 4'b0000, 1'b0};
    vecs[8] = '{5'h1F, 2'd0, 40'h123, 40'h456, 40'h123, 4'b0000, 1'b1};

    rst = 1'b1; hold = 1'b0;
    iss_vld = 1'b0; iss_op = '0; iss_dir = '0; op_a = '0; op_b = '0;
    #1;
    check("reset_result", 64'(res), 64'd0);
    check("reset_valid", 64'(res_vld), 64'd0);
    check("reset_flags", 64'({oz, oc, ov, on}), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].dir, vecs[i].a, vecs[i].b);
      #1;
      check($sformatf("vec%0d_stall_issue", i), 64'(stall), 64'd0);
      check($sformatf("vec%0d_cnt_issue", i), 64'(alu_cnt), 64'd0);
      tick();
      iss_vld = 1'b0;
      check($sformatf("vec%0d_valid", i), 64'(res_vld), 64'd1);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 64'({oz, oc, ov, on}), 64'(vecs[i].flags));
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
      check($sformatf("vec%0d_illegal", i), 64'(ill), 64'(vecs[i].illegal));
`endif
      tick();
      check($sformatf("vec%0d_valid_drop", i), 64'(res_vld), 64'd0);
      check($sformatf("vec%0d_result_hold", i), 64'(res), 64'(vecs[i].res));
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
      check($sformatf("vec%0d_illegal_drop", i), 64'(ill), 64'd0);
`endif
    end

    // ACCUMBYTES 0x030201 + 0x010101 -> 9, valid on the 4th edge after accept.
    issue(OP_ACCUMBYTES, 2'd0, 40'h03_0201, 40'h01_0101);
    #1;
    check("acc_cnt0", 64'(alu_cnt), 64'd0);
    check("acc_stall0", 64'(stall), 64'd0);
    tick();
    iss_vld = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("acc_cnt%0d", c), 64'(alu_cnt), 64'(c));
      check($sformatf("acc_stall%0d", c), 64'(stall), 64'd1);
      check($sformatf("acc_novalid%0d", c), 64'(res_vld), 64'd0);
      check($sformatf("acc_op%0d", c), 64'(alu_op), 64'(OP_ACCUMBYTES));
      check($sformatf("acc_b%0d", c), 64'(alu_b), 64'd0);
      tick();
    end
    check("acc_valid", 64'(res_vld), 64'd1);
    check("acc_result", 64'(res), 64'd9);
    check("acc_flags", 64'({oz, oc, ov, on}), 64'd0);
    check("acc_stall_done", 64'(stall), 64'd0);
    tick();
    check("acc_valid_drop", 64'(res_vld), 64'd0);

    // All bytes 0xFF; an ADD presented during ACCUM must be ignored.
    issue(OP_ACCUMBYTES, 2'd0, 40'hFF_FFFF, 40'hFF_FFFF);
    tick();
    issue(OP_ADD, 2'd0, 40'd100, 40'd200);
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("ff_op%0d", c), 64'(alu_op), 64'(OP_ACCUMBYTES));
      tick();
    end
    iss_vld = 1'b0;
    check("ff_valid", 64'(res_vld), 64'd1);
    check("ff_result", 64'(res), 64'd1530);
    tick();
    check("ff_no_extra_valid", 64'(res_vld), 64'd0);
    check("ff_result_kept", 64'(res), 64'd1530);

    // Hold at cnt=2 for three cycles, then two edges to the result.
    issue(OP_ACCUMBYTES, 2'd0, 40'h03_0201, 40'h01_0101);
    tick();
    iss_vld = 1'b0;
    tick();
    check("hold_cnt_pre", 64'(alu_cnt), 64'd2);
    a_snap = alu_a;
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      check($sformatf("hold_cnt%0d", h), 64'(alu_cnt), 64'd2);
      check($sformatf("hold_alu_a%0d", h), 64'(alu_a), 64'(a_snap));
      check($sformatf("hold_stall%0d", h), 64'(stall), 64'd1);
      check($sformatf("hold_novalid%0d", h), 64'(res_vld), 64'd0);
    end
    hold = 1'b0;
    tick();
    check("hold_rel_cnt3", 64'(alu_cnt), 64'd3);
    check("hold_rel_novalid", 64'(res_vld), 64'd0);
    tick();
    check("hold_rel_valid", 64'(res_vld), 64'd1);
    check("hold_rel_result", 64'(res), 64'd9);

    // Hold while valid is up stretches the pulse.
    hold = 1'b1;
    tick();
    check("hold_valid_stretch", 64'(res_vld), 64'd1);
    check("hold_valid_stall", 64'(stall), 64'd1);
    hold = 1'b0;
    tick();
    check("hold_valid_release", 64'(res_vld), 64'd0);

    // Reset mid-ACCUM aborts immediately.
    issue(OP_ACCUMBYTES, 2'd0, 40'hFF_FFFF, 40'hFF_FFFF);
    tick();
    iss_vld = 1'b0;
    check("rst_pre_cnt", 64'(alu_cnt), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_result", 64'(res), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_cnt", 64'(alu_cnt), 64'd0);
    check("rst_valid", 64'(res_vld), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_no_result", 64'(res_vld), 64'd0);
    issue(OP_ADD, 2'd0, 40'd5, 40'd7);
    tick();
    iss_vld = 1'b0;
    check("post_rst_valid", 64'(res_vld), 64'd1);
    check("post_rst_result", 64'(res), 64'd12);
    tick();
    check("post_rst_valid_drop", 64'(res_vld), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
